// File: rtl/cnn_stream_loader.sv
// rtl/cnn_stream_loader.sv - host-to-DNN sequencer: weight rows, then pixels, then wait for done
module cnn_stream_loader #(
    parameter int BitSize       = 4,
    parameter int ImageWidth    = 8,
    parameter int M_W_BitSize   = 4,
    parameter int MaxNumNerves  = 3,
    parameter int WeightRows    = 7,
    parameter int FrameCntWidth = 8,
    parameter int DrainTimeout  = 1024
) (
    input  logic                              clk,
    input  logic                              res,
    input  logic                              start,
    input  logic                              abort,
    input  logic [FrameCntWidth-1:0]          cfg_frames,
    input  logic                              cfg_reload,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [MaxNumNerves*M_W_BitSize-1:0] w_data,
    input  logic                              p_valid,
    output logic                              p_ready,
    input  logic [BitSize-1:0]                p_data,
    input  logic                              top_ready,
    input  logic                              dnn_done,
    output logic [MaxNumNerves*M_W_BitSize-1:0] out_weights,
    output logic                              out_w_valid,
    output logic [BitSize-1:0]                out_pix_data,
    output logic                              out_pix_valid,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              err
);
    localparam int WW   = MaxNumNerves * M_W_BitSize;
    localparam int NPix = ImageWidth * ImageWidth;
    localparam int RW   = (WeightRows > 1) ? $clog2(WeightRows) : 1;
    localparam int PW   = (NPix > 1) ? $clog2(NPix) : 1;
    localparam int DW   = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [RW-1:0] LastRow = RW'(WeightRows - 1);
    localparam logic [PW-1:0] LastPix = PW'(NPix - 1);
    localparam logic [DW-1:0] LastWd  = DW'(DrainTimeout - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t                   state_q;
    logic [RW-1:0]            row_cnt_q;
    logic [PW-1:0]            pix_cnt_q;
    logic [DW-1:0]            wdog_q;
    logic [FrameCntWidth-1:0] frame_cnt_q;
    logic [FrameCntWidth-1:0] frames_q;
    logic                     reload_q;
    logic                     err_q;
    logic                     frame_done_q;
    logic [WW-1:0]            out_weights_q;
    logic                     out_w_valid_q;
    logic [BitSize-1:0]       out_pix_data_q;
    logic                     out_pix_valid_q;

    logic   last_frame;
    logic   drain_end;
    state_t after_frame;

    // Readies are combinational so top_ready reaches the host in the same cycle.
    assign w_ready = (state_q == LOAD_W) && !abort;
    assign p_ready = (state_q == STREAM) && top_ready && !abort;

    assign last_frame  = (frame_cnt_q == frames_q - FrameCntWidth'(1));
    assign drain_end   = dnn_done || (wdog_q == LastWd);
    assign after_frame = last_frame ? IDLE : (reload_q ? LOAD_W : STREAM);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q         <= IDLE;
            row_cnt_q       <= '0;
            pix_cnt_q       <= '0;
            wdog_q          <= '0;
            frame_cnt_q     <= '0;
            frames_q        <= '0;
            reload_q        <= 1'b0;
            err_q           <= 1'b0;
            frame_done_q    <= 1'b0;
            out_weights_q   <= '0;
            out_w_valid_q   <= 1'b0;
            out_pix_data_q  <= '0;
            out_pix_valid_q <= 1'b0;
        end else begin
            out_w_valid_q   <= 1'b0;
            out_pix_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                row_cnt_q   <= '0;
                pix_cnt_q   <= '0;
                wdog_q      <= '0;
                frame_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            frames_q    <= (cfg_frames == '0) ? FrameCntWidth'(1) : cfg_frames;
                            reload_q    <= cfg_reload;
                            err_q       <= 1'b0;
                            row_cnt_q   <= '0;
                            pix_cnt_q   <= '0;
                            wdog_q      <= '0;
                            frame_cnt_q <= '0;
                            state_q     <= LOAD_W;
                        end
                    end
                    LOAD_W: begin
                        if (w_valid) begin
                            out_weights_q <= w_data;
                            out_w_valid_q <= 1'b1;
                            if (row_cnt_q == LastRow) begin
                                row_cnt_q <= '0;
                                state_q   <= STREAM;
                            end else begin
                                row_cnt_q <= row_cnt_q + RW'(1);
                            end
                        end
                    end
                    STREAM: begin
                        if (p_valid && top_ready) begin
                            out_pix_data_q  <= p_data;
                            out_pix_valid_q <= 1'b1;
                            if (pix_cnt_q == LastPix) begin
                                pix_cnt_q <= '0;
                                wdog_q    <= '0;
                                state_q   <= DRAIN;
                            end else begin
                                pix_cnt_q <= pix_cnt_q + PW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        // A done arriving on the watchdog's last cycle still counts as done.
                        if (drain_end) begin
                            frame_done_q <= 1'b1;
                            if (!dnn_done) err_q <= 1'b1;
                            frame_cnt_q  <= last_frame ? '0 : frame_cnt_q + FrameCntWidth'(1);
                            wdog_q       <= '0;
                            state_q      <= after_frame;
                        end else begin
                            wdog_q <= wdog_q + DW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_weights   = out_weights_q;
    assign out_w_valid   = out_w_valid_q;
    assign out_pix_data  = out_pix_data_q;
    assign out_pix_valid = out_pix_valid_q;
    assign frame_done    = frame_done_q;
    assign err           = err_q;
    assign busy          = (state_q != IDLE);
endmodule
